divider_bf16: RTL and testbench

Sequential bfloat16 divider computing output_div = input_a / input_b with round-to-nearest-even. It is the inverse-operation companion to the bf16 multiplier in the co-processor datapath and uses the identical STB/BUSY handshake on both sides, so the two units are interchangeable behind the same dispatch logic. A restoring shift-subtract loop produces one quotient bit per cycle.

---
 rtl/divider_bf16.sv | 195 +++++++++++++++++++
 tb/tb_divider_bf16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_bf16.sv
// Sequential bf16 divider (restoring, one quotient bit per cycle, RNE rounding).
// Define BF16_DIV_FTZ_EN to flush denormal inputs and results to signed zero.
module divider_bf16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_a,
  input  logic [15:0] input_b,
  input  logic        div_input_STB,
  output logic        div_BUSY,
  output logic [15:0] output_div,
  output logic        div_output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [3:0] {
    GET_A_AND_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, NORMALISE_1, NORMALISE_2,
    ROUND, PACK, PUT_Z
  } state_t;

  state_t             state;
  logic [15:0]        a, b, z;
  logic [7:0]         a_m, b_m, z_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic               guard, round_bit, sticky;
  logic [17:0]        dividend;
  logic [7:0]         rem;
  logic [10:0]        q;
  logic [3:0]         count;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [8:0]  rem_shift;
  logic [7:0]  rem_sub;
  logic        q_bit;
  logic [15:0] pack_z;

  always_comb begin
    a_nan = (a_e == 10'sd128) && (a_m[6:0] != 7'd0);
    b_nan = (b_e == 10'sd128) && (b_m[6:0] != 7'd0);
    a_inf = (a_e == 10'sd128) && (a_m[6:0] == 7'd0);
    b_inf = (b_e == 10'sd128) && (b_m[6:0] == 7'd0);
`ifdef BF16_DIV_FTZ_EN
    a_zero = (a_e == -10'sd127);
    b_zero = (b_e == -10'sd127);
`else
    a_zero = (a_e == -10'sd127) && (a_m == 8'd0);
    b_zero = (b_e == -10'sd127) && (b_m == 8'd0);
`endif
  end

  // The first seven quotient bits are always zero (a_m[7:1] < 128 <= b_m),
  // so step 0 consumes the top eight dividend bits at once.
  always_comb begin
    if (count == 4'd0) rem_shift = {1'b0, dividend[17:10]};
    else               rem_shift = {rem, dividend[9]};
    q_bit   = (rem_shift >= {1'b0, b_m});
    rem_sub = rem_shift[7:0] - b_m;
  end

  always_comb begin
    pack_z = {z_s, z_e[7:0] + 8'd127, z_m[6:0]};
    if (z_e == -10'sd126 && !z_m[7]) pack_z[14:7] = 8'd0;
    if (z_e > 10'sd127) pack_z = {z_s, 8'hFF, 7'd0};
`ifdef BF16_DIV_FTZ_EN
    if (z_e < -10'sd126) pack_z = {z_s, 15'd0};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= GET_A_AND_B;
      div_BUSY       <= 1'b0;
      div_output_STB <= 1'b0;
      output_div     <= 16'h0000;
    end else begin
      case (state)
        GET_A_AND_B: begin
          div_BUSY <= 1'b0;
          if (!div_BUSY && div_input_STB) begin
            a        <= input_a;
            b        <= input_b;
            div_BUSY <= 1'b1;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          a_m   <= {1'b0, a[6:0]};
          b_m   <= {1'b0, b[6:0]};
          a_e   <= $signed({2'b00, a[14:7]}) - 10'sd127;
          b_e   <= $signed({2'b00, b[14:7]}) - 10'sd127;
          a_s   <= a[15];
          b_s   <= b[15];
          state <= SPECIAL_CASES;
        end
        SPECIAL_CASES: begin
          state <= PUT_Z;
          if (a_nan || b_nan)        z <= 16'hFFC0;
          else if (a_inf && b_inf)   z <= 16'hFFC0;
          else if (a_zero && b_zero) z <= 16'hFFC0;
          else if (a_inf)            z <= {a_s ^ b_s, 8'hFF, 7'd0};
          else if (b_inf)            z <= {a_s ^ b_s, 15'd0};
          else if (b_zero)           z <= {a_s ^ b_s, 8'hFF, 7'd0};
          else if (a_zero)           z <= {a_s ^ b_s, 15'd0};
          else begin
            if (a_e == -10'sd127) a_e <= -10'sd126;
            else                  a_m[7] <= 1'b1;
            if (b_e == -10'sd127) b_e <= -10'sd126;
            else                  b_m[7] <= 1'b1;
            state <= NORMALISE_A;
          end
        end
        NORMALISE_A: begin
          if (!a_m[7]) begin
            a_m <= a_m << 1;
            a_e <= a_e - 10'sd1;
          end else state <= NORMALISE_B;
        end
        NORMALISE_B: begin
          if (!b_m[7]) begin
            b_m <= b_m << 1;
            b_e <= b_e - 10'sd1;
          end else state <= DIVIDE_0;
        end
        DIVIDE_0: begin
          z_s      <= a_s ^ b_s;
          z_e      <= a_e - b_e;
          dividend <= {a_m, 10'd0};
          rem      <= 8'd0;
          q        <= 11'd0;
          count    <= 4'd0;
          state    <= DIVIDE_1;
        end
        DIVIDE_1: begin
          q   <= {q[9:0], q_bit};
          rem <= q_bit ? rem_sub : rem_shift[7:0];
          if (count != 4'd0) dividend <= dividend << 1;
          count <= count + 4'd1;
          if (count == 4'd10) state <= DIVIDE_2;
        end
        DIVIDE_2: begin
          z_m       <= q[10:3];
          guard     <= q[2];
          round_bit <= q[1];
          sticky    <= q[0] | (rem != 8'd0);
          state     <= NORMALISE_1;
        end
        NORMALISE_1: begin
          if (!z_m[7]) begin
            z_m       <= {z_m[6:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end else begin
`ifdef BF16_DIV_FTZ_EN
            state <= ROUND;
`else
            state <= NORMALISE_2;
`endif
          end
        end
        NORMALISE_2: begin
          if (z_e < -10'sd126) begin
            z_m       <= z_m >> 1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
            z_e       <= z_e + 10'sd1;
          end else state <= ROUND;
        end
        ROUND: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            z_m <= z_m + 8'd1;
            if (z_m == 8'hFF) z_e <= z_e + 10'sd1;
          end
          state <= PACK;
        end
        PACK: begin
          z     <= pack_z;
          state <= PUT_Z;
        end
        PUT_Z: begin
          div_output_STB <= 1'b1;
          output_div     <= z;
          if (div_output_STB && !output_module_BUSY) begin
            div_output_STB <= 1'b0;
            state          <= GET_A_AND_B;
          end
        end
        default: state <= GET_A_AND_B;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_bf16.sv
// Directed self-checking bench for divider_bf16: results, latency, handshake, reset.
module tb_divider_bf16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] input_a, input_b;
  logic        div_input_STB;
  logic        div_BUSY;
  logic [15:0] output_div;
  logic        div_output_STB;
  logic        output_module_BUSY;

  int checks = 0;
  int errors = 0;

  divider_bf16 dut (
    .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
    .div_input_STB(div_input_STB), .div_BUSY(div_BUSY), .output_div(output_div),
    .div_output_STB(div_output_STB), .output_module_BUSY(output_module_BUSY)
  );

  always #5 clk = ~clk;

  // Present one operand pair, then count edges after the accepting edge until STB.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] z, output int lat);
    @(posedge clk); #1;
    input_a = a; input_b = b; div_input_STB = 1'b1;
    @(posedge clk); #1;
    div_input_STB = 1'b0;
    lat = 0;
    while (!div_output_STB && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    z = output_div;
  endtask

  task automatic release_result();
    output_module_BUSY = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; div_input_STB = 1'b0; output_module_BUSY = 1'b0;
    input_a = 16'h0; input_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (div_BUSY !== 1'b0 || div_output_STB !== 1'b0 || output_div !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b stb=%b out=%h, want 0 0 0000", div_BUSY, div_output_STB, output_div);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [15:0] va[4], vb[4], vz[4];
    int vl[4];
    logic [15:0] z;
    int lat;
    va = '{16'h40C0, 16'h3F80, 16'h3F80, 16'hBF80};
    vb = '{16'h4040, 16'h4000, 16'h4040, 16'h4000};
    vz = '{16'h4000, 16'h3F00, 16'h3EAB, 16'hBF00};
    vl = '{22, 22, 23, 22};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], z, lat);
      checks++;
      if (z !== vz[i]) begin
        errors++;
        $display("FAIL normal[%0d] value: got %h want %h", i, z, vz[i]);
      end
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL normal[%0d] latency: got %0d want %0d", i, lat, vl[i]);
      end
      release_result();
    end
  endtask

  task automatic test_special();
    logic [15:0] va[5], vb[5], vz[5];
    logic [15:0] z;
    int lat;
    va = '{16'h3F80, 16'h0000, 16'h7F80, 16'h3F80, 16'h7FC1};
    vb = '{16'h0000, 16'h0000, 16'h7F80, 16'h7F80, 16'h3F80};
    vz = '{16'h7F80, 16'hFFC0, 16'hFFC0, 16'h0000, 16'hFFC0};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], z, lat);
      checks++;
      if (z !== vz[i]) begin
        errors++;
        $display("FAIL special[%0d] value: got %h want %h", i, z, vz[i]);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL special[%0d] latency: got %0d want 3", i, lat);
      end
      release_result();
    end
  endtask

  task automatic test_range();
    logic [15:0] z, dz;
    int lat, dl;
    run_op(16'h7F7F, 16'h3F00, z, lat);
    checks++;
    if (z !== 16'h7F80 || lat != 22) begin
      errors++;
      $display("FAIL overflow: got %h lat %0d want 7f80 lat 22", z, lat);
    end
    release_result();
`ifdef BF16_DIV_FTZ_EN
    dz = 16'h0000; dl = 3;
`else
    dz = 16'h0001; dl = 35;
`endif
    run_op(16'h0002, 16'h4000, z, lat);
    checks++;
    if (z !== dz) begin
      errors++;
      $display("FAIL denormal value: got %h want %h", z, dz);
    end
    checks++;
    if (lat != dl) begin
      errors++;
      $display("FAIL denormal latency: got %0d want %0d", lat, dl);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [15:0] z;
    int lat;
    output_module_BUSY = 1'b1;
    run_op(16'h40C0, 16'h4040, z, lat);
    checks++;
    if (z !== 16'h4000 || lat != 22) begin
      errors++;
      $display("FAIL bp result: got %h lat %0d want 4000 lat 22", z, lat);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        input_a = 16'h3F80; input_b = 16'h4040; div_input_STB = 1'b1;
      end
      if (i == 4) div_input_STB = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (div_output_STB !== 1'b1 || div_BUSY !== 1'b1 || output_div !== 16'h4000) begin
        errors++;
        $display("FAIL bp hold[%0d]: stb=%b busy=%b out=%h want 1 1 4000",
                 i, div_output_STB, div_BUSY, output_div);
      end
    end
    output_module_BUSY = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (div_output_STB !== 1'b0 || div_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL bp release: stb=%b busy=%b want 0 1", div_output_STB, div_BUSY);
    end
    @(posedge clk); #1;
    checks++;
    if (div_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL bp busy drop: busy=%b want 0", div_BUSY);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_BUSY !== 1'b0 || div_output_STB !== 1'b0) begin
      errors++;
      $display("FAIL bp ignored strobe: busy=%b stb=%b want 0 0", div_BUSY, div_output_STB);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] z;
    int lat;
    @(posedge clk); #1;
    input_a = 16'h40C0; input_b = 16'h4040; div_input_STB = 1'b1;
    @(posedge clk); #1;
    div_input_STB = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_output_STB !== 1'b0 || div_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: stb=%b busy=%b want 0 0", div_output_STB, div_BUSY);
    end
    rst = 1'b0;
    run_op(16'h3F80, 16'h4040, z, lat);
    checks++;
    if (z !== 16'h3EAB) begin
      errors++;
      $display("FAIL after reset value: got %h want 3eab", z);
    end
    checks++;
    if (lat != 23) begin
      errors++;
      $display("FAIL after reset latency: got %0d want 23", lat);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
